// File: rtl/dla_feeder_config_dispatch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dla_feeder_config_dispatch_pkg
// Purpose  : Shared types, destination IDs and header decode for the input
//            feeder config dispatcher.
// Revision : 1.0  initial release
// ============================================================================
package dla_feeder_config_dispatch_pkg;

    // Packet parser states
    typedef enum logic [1:0] {
        ST_HEADER  = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_DRAIN   = 2'd2
    } state_e;

    // Error codes reported on o_error_code
    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_ZERO_LEN = 2'd1,
        ERR_BAD_DEST = 2'd2
    } err_code_e;

    // Destination channel IDs
    localparam int unsigned DEST_MUX    = 0;
    localparam int unsigned DEST_WRITER = 1;
    localparam int unsigned DEST_IN     = 2;
    localparam int unsigned DEST_READER = 3;
    localparam int unsigned DEST_OUT    = 4;

    // Decoded header fields, sized generously; callers truncate to their widths
    typedef struct packed {
        logic [7:0]  dest;
        logic [31:0] len;
    } hdr_t;

    // Extract length from the low bits and destination from the field above it;
    // everything above the destination field is ignored.
    function automatic hdr_t decode_header(input logic [63:0] hdr,
                                           input int unsigned len_w,
                                           input int unsigned dest_w);
        hdr_t        r;
        logic [63:0] len_mask;
        logic [63:0] dest_mask;
        len_mask  = (64'd1 << len_w) - 64'd1;
        dest_mask = (64'd1 << dest_w) - 64'd1;
        r.len     = 32'(hdr & len_mask);
        r.dest    = 8'((hdr >> len_w) & dest_mask);
        return r;
    endfunction

endpackage : dla_feeder_config_dispatch_pkg
`default_nettype wire

// File: rtl/dla_feeder_config_dispatch_out_stage.sv
`default_nettype none
// ============================================================================
// Module   : dla_feeder_config_dispatch_out_stage
// Purpose  : Single-entry registered output holding one payload word with a
//            destination tag, fanned out as a one-hot valid vector.
// Revision : 1.0  initial release
// ============================================================================
module dla_feeder_config_dispatch_out_stage #(
    parameter int CONFIG_WIDTH = 32,
    parameter int NUM_DEST     = 5,
    parameter int SEL_WIDTH    = 3
) (
    input  logic                    clk,
    input  logic                    i_sclr,
    input  logic                    i_load,
    input  logic [CONFIG_WIDTH-1:0] i_load_data,
    input  logic [SEL_WIDTH-1:0]    i_load_dest,
    input  logic [NUM_DEST-1:0]     i_dest_ready,
    output logic [CONFIG_WIDTH-1:0] o_dest_data,
    output logic [NUM_DEST-1:0]     o_dest_valid,
    output logic                    o_valid,
    output logic                    o_can_accept
);

    logic                    valid_q;
    logic [SEL_WIDTH-1:0]    dest_q;
    logic [CONFIG_WIDTH-1:0] data_q;
    logic                    w_handshake;

    // Only the addressed channel's ready can complete the handshake
    assign w_handshake  = |(o_dest_valid & i_dest_ready);
    assign o_can_accept = !valid_q || w_handshake;
    assign o_valid      = valid_q;
    assign o_dest_data  = data_q;

    generate
        for (genvar k = 0; k < NUM_DEST; k++) begin : g_fanout
            assign o_dest_valid[k] = valid_q && (dest_q == SEL_WIDTH'(k));
        end
    endgenerate

    // Load takes priority over draining so a same-cycle reload keeps the stage full
    always_ff @(posedge clk) begin
        if (i_sclr) begin
            valid_q <= 1'b0;
            dest_q  <= '0;
            data_q  <= '0;
        end else if (i_load) begin
            valid_q <= 1'b1;
            dest_q  <= i_load_dest;
            data_q  <= i_load_data;
        end else if (w_handshake) begin
            valid_q <= 1'b0;
        end
    end

endmodule : dla_feeder_config_dispatch_out_stage
`default_nettype wire

// File: rtl/dla_feeder_config_dispatcher.sv
`default_nettype none
// ============================================================================
// Module   : dla_feeder_config_dispatcher
// Purpose  : Splits a serial header+payload config stream into the five
//            input-feeder config channels (mux, writer, in, reader, out).
// Revision : 1.0  initial release
// ============================================================================
module dla_feeder_config_dispatcher
    import dla_feeder_config_dispatch_pkg::*;
#(
    parameter int CONFIG_WIDTH = 32,
    parameter int NUM_DEST     = 5,
    parameter int LEN_WIDTH    = 16,
    parameter int DEST_WIDTH   = 3
) (
    input  logic                    clk,
    input  logic                    i_sclr,
    input  logic [CONFIG_WIDTH-1:0] i_config_data,
    input  logic                    i_config_valid,
    output logic                    o_config_ready,
    output logic [CONFIG_WIDTH-1:0] o_dest_data,
    output logic [NUM_DEST-1:0]     o_dest_valid,
    input  logic [NUM_DEST-1:0]     i_dest_ready,
    output logic                    o_busy,
    output logic                    o_error,
    output logic [1:0]              o_error_code,
    input  logic                    i_error_clear
);

    localparam logic [7:0] C_NUM_DEST = 8'(NUM_DEST);

    state_e                 state_q, state_d;
    logic [LEN_WIDTH-1:0]   cnt_q, cnt_d;
    logic [DEST_WIDTH-1:0]  sel_q, sel_d;
    logic                   error_q;
    err_code_e              err_code_q;

    hdr_t                   w_hdr;
    logic [LEN_WIDTH-1:0]   w_hdr_len;
    logic [DEST_WIDTH-1:0]  w_hdr_dest;
    logic                   w_len_zero;
    logic                   w_dest_bad;
    logic                   w_accept;
    logic                   w_load;
    logic                   w_stage_can_accept;
    logic                   w_stage_valid;
    logic                   w_err_set;
    err_code_e              w_err_code;

    assign w_hdr      = decode_header(64'(i_config_data), LEN_WIDTH, DEST_WIDTH);
    assign w_hdr_len  = LEN_WIDTH'(w_hdr.len);
    assign w_hdr_dest = DEST_WIDTH'(w_hdr.dest);
    assign w_len_zero = (w_hdr.len == 32'd0);
    assign w_dest_bad = (w_hdr.dest >= C_NUM_DEST);

    // Only payload words can be back-pressured; headers and drained words always flow
    assign o_config_ready = (state_q == ST_PAYLOAD) ? w_stage_can_accept : 1'b1;
    assign w_accept       = i_config_valid && o_config_ready;
    assign o_busy         = (state_q != ST_HEADER) || w_stage_valid;
    assign o_error        = error_q;
    assign o_error_code   = err_code_q;

    // Next-state decode of the packet parser
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sel_d      = sel_q;
        w_load     = 1'b0;
        w_err_set  = 1'b0;
        w_err_code = ERR_NONE;
        case (state_q)
            ST_HEADER: begin
                if (w_accept) begin
                    if (w_len_zero) begin
                        w_err_set  = 1'b1;
                        w_err_code = ERR_ZERO_LEN;
                    end else if (w_dest_bad) begin
                        w_err_set  = 1'b1;
                        w_err_code = ERR_BAD_DEST;
                        cnt_d      = w_hdr_len;
                        state_d    = ST_DRAIN;
                    end else begin
                        cnt_d   = w_hdr_len;
                        sel_d   = w_hdr_dest;
                        state_d = ST_PAYLOAD;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (w_accept) begin
                    w_load = 1'b1;
                    cnt_d  = cnt_q - LEN_WIDTH'(1);
                    if (cnt_q == LEN_WIDTH'(1)) begin
                        state_d = ST_HEADER;
                    end
                end
            end
            ST_DRAIN: begin
                if (w_accept) begin
                    cnt_d = cnt_q - LEN_WIDTH'(1);
                    if (cnt_q == LEN_WIDTH'(1)) begin
                        state_d = ST_HEADER;
                    end
                end
            end
            default: state_d = ST_HEADER;
        endcase
    end

    // Parser state, remaining-length counter and latched destination
    always_ff @(posedge clk) begin
        if (i_sclr) begin
            state_q <= ST_HEADER;
            cnt_q   <= '0;
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
        end
    end

    // Sticky error keeps only the first code; a clear beats a simultaneous new error
    always_ff @(posedge clk) begin
        if (i_sclr || i_error_clear) begin
            error_q    <= 1'b0;
            err_code_q <= ERR_NONE;
        end else if (w_err_set && !error_q) begin
            error_q    <= 1'b1;
            err_code_q <= w_err_code;
        end
    end

    dla_feeder_config_dispatch_out_stage #(
        .CONFIG_WIDTH (CONFIG_WIDTH),
        .NUM_DEST     (NUM_DEST),
        .SEL_WIDTH    (DEST_WIDTH)
    ) u_out_stage (
        .clk          (clk),
        .i_sclr       (i_sclr),
        .i_load       (w_load),
        .i_load_data  (i_config_data),
        .i_load_dest  (sel_q),
        .i_dest_ready (i_dest_ready),
        .o_dest_data  (o_dest_data),
        .o_dest_valid (o_dest_valid),
        .o_valid      (w_stage_valid),
        .o_can_accept (w_stage_can_accept)
    );

    // A stalled sender must keep its word unchanged until accepted
    property p_hold_while_stalled;
        @(posedge clk) disable iff (i_sclr)
        (i_config_valid && !o_config_ready) |=> $stable(i_config_data);
    endproperty
    a_hold_while_stalled: assert property (p_hold_while_stalled);

endmodule : dla_feeder_config_dispatcher
`default_nettype wire
